// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared encodings for the camera stream generator:
//                pattern_sel codes, RGB444 byte packing, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package cam_pkg;

    // pattern_sel encodings
    localparam logic [1:0] c_PAT_SOLID = 2'd0;
    localparam logic [1:0] c_PAT_BARS  = 2'd1;
    localparam logic [1:0] c_PAT_GRAD  = 2'd2;
    localparam logic [1:0] c_PAT_CHECK = 2'd3;

    // RGB444 nibble constants
    localparam logic [3:0] c_NIB_ZERO = 4'h0;
    localparam logic [3:0] c_NIB_FULL = 4'hF;

    // FSM state encodings
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // First byte of a pixel carries R in the low nibble, second byte carries {G,B}
    function automatic logic [7:0] pack_byte(input rgb444_t rgb, input logic odd);
        return odd ? {rgb.g, rgb.b} : {c_NIB_ZERO, rgb.r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pattern_rgb.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pattern_rgb
//  Description : Combinational test-pattern generator: pixel x, line y and
//                frame number to an RGB444 colour for the selected pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module cam_pattern_rgb
    import cam_pkg::*;
#(
    parameter int IMG_W = 160
) (
    input  logic [15:0] x,
    input  logic [3:0]  y,
    input  logic [3:0]  frame,
    input  logic [1:0]  sel,
    input  logic [11:0] solid_color,
    output rgb444_t     rgb
);

    // Eight equal-width bars across the active line
    logic [2:0] w_k;
    assign w_k = 3'((32'(x) << 3) / 32'(IMG_W));

    // Colour selection per pattern
    always_comb begin
        rgb = '0;
        case (sel)
            c_PAT_SOLID: rgb = solid_color;
            c_PAT_BARS: begin
                rgb.r = w_k[2] ? c_NIB_FULL : c_NIB_ZERO;
                rgb.g = w_k[1] ? c_NIB_FULL : c_NIB_ZERO;
                rgb.b = w_k[0] ? c_NIB_FULL : c_NIB_ZERO;
            end
            c_PAT_GRAD:  rgb = {x[3:0], y, frame};
            c_PAT_CHECK: rgb = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            default:     rgb = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cam_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cam_stream_gen
//  Description : OV7670-style camera transmitter (pclk/vsync/href/8-bit data,
//                two bytes per RGB444 pixel) for board bring-up.
//                Optional macro CAM_GEN_FRAME_CNT_EN adds the 16-bit
//                frame_cnt output counting completed frames.
//  Revision    : 1.0  initial release
// ============================================================================
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int BLANK_COL  = 4,
    parameter int BLANK_ROW  = 4,
    parameter int VSYNC_ROWS = 2,
    parameter int PCLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic        busy
`ifdef CAM_GEN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int c_COLS  = 2 * IMG_W + BLANK_COL;
    localparam int c_ROWS  = BLANK_ROW + IMG_H;
    localparam int c_COL_W = $clog2(c_COLS);
    localparam int c_ROW_W = $clog2(c_ROWS);
    localparam int c_DIV_W = $clog2(PCLK_DIV);

    localparam logic [c_COL_W-1:0] c_COL_MAX       = c_COL_W'(c_COLS - 1);
    localparam logic [c_COL_W-1:0] c_COL_ACTIVE    = c_COL_W'(2 * IMG_W);
    localparam logic [c_COL_W-1:0] c_COL_LAST_BYTE = c_COL_W'(2 * IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX       = c_ROW_W'(c_ROWS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_BLANK     = c_ROW_W'(BLANK_ROW);
    localparam logic [c_ROW_W-1:0] c_ROW_VS        = c_ROW_W'(VSYNC_ROWS);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX       = c_DIV_W'(PCLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF      = c_DIV_W'(PCLK_DIV / 2);

    logic [c_DIV_W-1:0] r_div;
    logic [0:0]         r_state;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [1:0]         r_sel;
    logic [11:0]        r_solid;
    logic [3:0]         r_frame;

    logic [c_DIV_W-1:0] w_div_nxt;
    logic               w_fall;
    logic               w_col_last;
    logic               w_row_last;
    logic [c_COL_W-1:0] w_ncol;
    logic [c_ROW_W-1:0] w_nrow;
    logic [c_COL_W-1:0] w_pcol;
    logic [c_ROW_W-1:0] w_prow;
    logic               w_wrap;
    logic               w_stop;
    logic               w_emit;
    logic               w_frame_start;
    logic               w_done_set;
    logic               w_vsync;
    logic               w_href;
    logic [15:0]        w_x;
    logic [3:0]         w_y;
    rgb444_t            w_rgb;
    logic [7:0]         w_byte;

    // pclk phase: the last clk of a period is the one whose edge drops pclk
    assign w_div_nxt = (r_div == c_DIV_MAX) ? '0 : r_div + c_DIV_W'(1);
    assign w_fall    = (r_div == c_DIV_MAX);

    // Next raster position while running; a new frame starts at (0,0) from IDLE
    assign w_col_last = (r_col == c_COL_MAX);
    assign w_row_last = (r_row == c_ROW_MAX);
    assign w_ncol     = w_col_last ? '0 : r_col + c_COL_W'(1);
    assign w_nrow     = w_col_last ? (w_row_last ? '0 : r_row + c_ROW_W'(1)) : r_row;
    assign w_pcol     = (r_state == c_ST_IDLE) ? '0 : w_ncol;
    assign w_prow     = (r_state == c_ST_IDLE) ? '0 : w_nrow;

    assign w_wrap = (r_state == c_ST_RUN) && w_col_last && w_row_last;
    assign w_stop = w_wrap && !enable;
    assign w_emit = w_fall && (((r_state == c_ST_IDLE) && enable) ||
                               ((r_state == c_ST_RUN) && !w_stop));

    assign w_frame_start = (w_pcol == '0) && (w_prow == '0);
    assign w_done_set    = w_emit && (r_state == c_ST_RUN) &&
                           (w_prow == c_ROW_MAX) && (w_pcol == c_COL_LAST_BYTE);

    // Sync levels and pixel coordinates for the position about to be emitted
    assign w_vsync = (w_prow < c_ROW_VS);
    assign w_href  = (w_prow >= c_ROW_BLANK) && (w_pcol < c_COL_ACTIVE);
    assign w_x     = 16'(w_pcol >> 1);
    assign w_y     = 4'(w_prow - c_ROW_BLANK);
    assign w_byte  = pack_byte(w_rgb, w_pcol[0]);
    assign busy    = (r_state == c_ST_RUN);

    cam_pattern_rgb #(
        .IMG_W (IMG_W)
    ) u_pattern (
        .x           (w_x),
        .y           (w_y),
        .frame       (r_frame),
        .sel         (r_sel),
        .solid_color (r_solid),
        .rgb         (w_rgb)
    );

    // Free-running pclk divider: low for the first half period, high for the second
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            CAM_pclk <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            CAM_pclk <= (w_div_nxt >= c_DIV_HALF);
        end
    end

    // Frame state and raster position, stepped once per pclk on its falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_emit) begin
            r_state <= c_ST_RUN;
            r_col   <= w_pcol;
            r_row   <= w_prow;
        end else if (w_fall && w_stop) begin
            r_state <= c_ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end
    end

    // Pattern settings are captured as the first position of a frame goes out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= c_PAT_SOLID;
            r_solid <= '0;
        end else if (w_emit && w_frame_start) begin
            r_sel   <= pattern_sel;
            r_solid <= solid_color;
        end
    end

    // Frame number used by the gradient pattern, steps at every frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
        end else if (w_fall && w_wrap) begin
            r_frame <= r_frame + 4'd1;
        end
    end

    // Camera bus outputs, all updated on the clk edge that drops pclk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= 8'h00;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= w_done_set;
            if (w_emit) begin
                CAM_vsync   <= w_vsync;
                CAM_href    <= w_href;
                CAM_px_data <= w_href ? w_byte : 8'h00;
            end else if (w_fall && w_stop) begin
                CAM_vsync   <= 1'b0;
                CAM_href    <= 1'b0;
                CAM_px_data <= 8'h00;
            end
        end
    end

`ifdef CAM_GEN_FRAME_CNT_EN
    // Completed-frame count, stepping together with frame_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (w_done_set) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_stream_gen
//  Description : Self-checking bench for cam_stream_gen with a small image.
//                Captures the camera bus at each pclk rise and compares it
//                with a frame model computed from the raster/pattern rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cam_stream_gen;

    localparam int IMG_W       = 4;
    localparam int IMG_H       = 2;
    localparam int BLANK_COL   = 2;
    localparam int BLANK_ROW   = 2;
    localparam int VSYNC_ROWS  = 1;
    localparam int PCLK_DIV    = 4;
    localparam int COLS        = 2 * IMG_W + BLANK_COL;
    localparam int ROWS        = BLANK_ROW + IMG_H;
    localparam int FRAME_PCLKS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_color;
    logic        CAM_pclk;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic        frame_done;
    logic        busy;
`ifdef CAM_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    logic [9:0] cap [FRAME_PCLKS];

    cam_stream_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BLANK_COL  (BLANK_COL),
        .BLANK_ROW  (BLANK_ROW),
        .VSYNC_ROWS (VSYNC_ROWS),
        .PCLK_DIV   (PCLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .frame_done  (frame_done),
        .busy        (busy)
`ifdef CAM_GEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // frame_done pulses seen, sampled mid-cycle
    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    // Reference: {vsync, href, data} expected at raster position (row, col)
    function automatic logic [9:0] exp_out(int row, int col, int sel, logic [11:0] solid, int frame);
        int x, y, k, r, g, b;
        logic vs, hr;
        logic [7:0] d;
        vs = (row < VSYNC_ROWS);
        hr = (row >= BLANK_ROW) && (col < 2 * IMG_W);
        x  = col / 2;
        y  = row - BLANK_ROW;
        r = 0; g = 0; b = 0;
        case (sel)
            0: begin r = int'(solid[11:8]); g = int'(solid[7:4]); b = int'(solid[3:0]); end
            1: begin
                k = x * 8 / IMG_W;
                r = (k & 4) != 0 ? 15 : 0;
                g = (k & 2) != 0 ? 15 : 0;
                b = (k & 1) != 0 ? 15 : 0;
            end
            2: begin r = x % 16; g = (y + 16) % 16; b = frame % 16; end
            default: begin
                if ((((x / 8) ^ ((y + 16) / 8)) & 1) != 0) begin r = 15; g = 15; b = 15; end
            end
        endcase
        d = (col % 2 == 0) ? 8'(r) : 8'(g * 16 + b);
        if (!hr) d = 8'h00;
        return {vs, hr, d};
    endfunction

    task automatic wait_pclk_rise();
        logic prev;
        bit   got;
        prev = CAM_pclk;
        got  = 0;
        for (int n = 0; n < 4 * PCLK_DIV && !got; n++) begin
            @(negedge clk);
            if (!prev && CAM_pclk) got = 1;
            prev = CAM_pclk;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pclk_timeout got no rise in %0d clks, required a rise", 4 * PCLK_DIV);
        end
    endtask

    task automatic wait_busy();
        bit got;
        got = 0;
        for (int n = 0; n < 8 * PCLK_DIV && !got; n++) begin
            if (busy === 1'b1) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout busy=%b, required 1", busy);
        end
    endtask

    task automatic do_reset(input bit en, input logic [1:0] sel, input logic [11:0] solid);
        @(negedge clk);
        rst = 1'b1;
        enable = en;
        pattern_sel = sel;
        solid_color = solid;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Record one frame of pclk-rise samples; optionally change inputs after sample chg_idx
    task automatic capture_frame(input int chg_idx, input bit n_en, input logic [1:0] n_sel,
                                 input logic [11:0] n_solid);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            wait_pclk_rise();
            cap[i] = {CAM_vsync, CAM_href, CAM_px_data};
            if (i == chg_idx) begin
                enable = n_en;
                pattern_sel = n_sel;
                solid_color = n_solid;
            end
        end
    endtask

    task automatic test_reset();
        logic exp_pclk, exp_busy;
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        pattern_sel = 2'd0;
        solid_color = 12'hFFF;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy} !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs got %b required 0",
                         {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy});
            end
        end
`ifdef CAM_GEN_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d required 0", frame_cnt);
        end
`endif
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_pclk = ((k % PCLK_DIV) >= PCLK_DIV / 2);
            exp_busy = (k >= PCLK_DIV);
            checks++;
            if (CAM_pclk !== exp_pclk) begin
                errors++;
                $display("FAIL pclk_wave clk %0d got %b required %b", k, CAM_pclk, exp_pclk);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy_start clk %0d got %b required %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_solid();
        int fd0, nvs, nhr, nlines;
        logic [9:0] e;
        bit line_hr;
        do_reset(1'b1, 2'd0, 12'hA5C);
        wait_busy();
        fd0 = fd_cnt;
        capture_frame(-1, 1'b1, 2'd0, 12'hA5C);
        nvs = 0; nhr = 0; nlines = 0;
        for (int r = 0; r < ROWS; r++) begin
            line_hr = 0;
            for (int c = 0; c < COLS; c++) begin
                e = exp_out(r, c, 0, 12'hA5C, 0);
                checks++;
                if (cap[r * COLS + c] !== e) begin
                    errors++;
                    $display("FAIL solid r%0d c%0d got %h required %h", r, c, cap[r * COLS + c], e);
                end
                if (cap[r * COLS + c][9]) nvs++;
                if (cap[r * COLS + c][8]) begin nhr++; line_hr = 1; end
            end
            if (line_hr) nlines++;
        end
        checks++;
        if (nvs != COLS) begin errors++; $display("FAIL vsync_len got %0d required %0d", nvs, COLS); end
        checks++;
        if (nhr != 2 * IMG_W * IMG_H) begin
            errors++; $display("FAIL href_count got %0d required %0d", nhr, 2 * IMG_W * IMG_H);
        end
        checks++;
        if (nlines != IMG_H) begin errors++; $display("FAIL href_lines got %0d required %0d", nlines, IMG_H); end
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL solid_done got %0d required 1", fd_cnt - fd0); end
    endtask

    task automatic test_bars();
        logic [9:0] e;
        logic [11:0] s;
        s = 12'($urandom);
        do_reset(1'b1, 2'd1, s);
        wait_busy();
        capture_frame(-1, 1'b1, 2'd1, s);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            e = exp_out(i / COLS, i % COLS, 1, s, 0);
            checks++;
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL bars idx %0d got %h required %h", i, cap[i], e);
            end
        end
    endtask

    task automatic test_enable_drop();
        int fd0;
        logic [9:0] e;
        do_reset(1'b1, 2'd2, 12'h000);
        wait_busy();
        fd0 = fd_cnt;
        capture_frame(3 * COLS + 1, 1'b0, 2'd2, 12'h000);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            e = exp_out(i / COLS, i % COLS, 2, 12'h000, 0);
            checks++;
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL drop_frame idx %0d got %h required %h", i, cap[i], e);
            end
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checks++;
            if ({busy, CAM_vsync, CAM_href, CAM_px_data, frame_done} !== 12'b0) begin
                errors++;
                $display("FAIL drop_idle clk %0d got %b required 0", n,
                         {busy, CAM_vsync, CAM_href, CAM_px_data, frame_done});
            end
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL drop_done got %0d required 1", fd_cnt - fd0); end
        enable = 1'b0;
    endtask

    task automatic test_sel_change();
        logic [9:0] e;
        logic [11:0] s;
        s = 12'($urandom) | 12'h111;
        do_reset(1'b1, 2'd0, s);
        wait_busy();
        capture_frame(20, 1'b1, 2'd3, s);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            e = exp_out(i / COLS, i % COLS, 0, s, 0);
            checks++;
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL selchg_old idx %0d got %h required %h", i, cap[i], e);
            end
        end
        capture_frame(-1, 1'b1, 2'd3, s);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            e = exp_out(i / COLS, i % COLS, 3, s, 1);
            checks++;
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL selchg_new idx %0d got %h required %h", i, cap[i], e);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  cur_sel, nxt_sel;
        logic [11:0] cur_sol, nxt_sol;
        logic [9:0]  e;
        int fd0;
        cur_sel = 2'($urandom);
        cur_sol = 12'($urandom);
        do_reset(1'b1, cur_sel, cur_sol);
        wait_busy();
        for (int f = 0; f < 20; f++) begin
            nxt_sel = 2'($urandom);
            nxt_sol = 12'($urandom);
            fd0 = fd_cnt;
            capture_frame(int'($urandom_range(2, FRAME_PCLKS - 3)), 1'b1, nxt_sel, nxt_sol);
            for (int i = 0; i < FRAME_PCLKS; i++) begin
                e = exp_out(i / COLS, i % COLS, int'(cur_sel), cur_sol, f);
                checks++;
                if (cap[i] !== e) begin
                    errors++;
                    $display("FAIL random f%0d sel%0d idx %0d got %h required %h",
                             f, cur_sel, i, cap[i], e);
                end
            end
            checks++;
            if (fd_cnt - fd0 != 1) begin
                errors++; $display("FAIL random_done f%0d got %0d required 1", f, fd_cnt - fd0);
            end
            cur_sel = nxt_sel;
            cur_sol = nxt_sol;
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] e;
        int fd0;
        do_reset(1'b1, 2'd2, 12'h000);
        wait_busy();
        fd0 = fd_cnt;
        repeat (3) capture_frame(-1, 1'b1, 2'd2, 12'h000);
        checks++;
        if (fd_cnt - fd0 != 3) begin errors++; $display("FAIL three_frames got %0d required 3", fd_cnt - fd0); end
`ifdef CAM_GEN_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt got %0d required 3", frame_cnt); end
`endif
        repeat (int'($urandom_range(3, FRAME_PCLKS / 2))) wait_pclk_rise();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy} !== 13'b0) begin
            errors++;
            $display("FAIL async_reset got %b required 0",
                     {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy});
        end
`ifdef CAM_GEN_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d required 0", frame_cnt); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_busy();
        capture_frame(-1, 1'b1, 2'd2, 12'h000);
        for (int i = 0; i < FRAME_PCLKS; i++) begin
            e = exp_out(i / COLS, i % COLS, 2, 12'h000, 0);
            checks++;
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL restart idx %0d got %h required %h", i, cap[i], e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 12'h000;
        test_reset();
        test_solid();
        test_bars();
        test_enable_drop();
        test_sel_change();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
